pbkdf2_sha256_ctrl: RTL
=======================

Name: pbkdf2_sha256_ctrl

Overview:
- PBKDF2-HMAC-SHA256 iteration controller; the initiator side of the hmac_sha256 request/response interface.
- Takes password, salt, iteration count and block index, and issues c HMAC requests.
- XOR-accumulates U_1..U_c into one 256-bit derived-key block T_i.
- Sits between the top-level job interface and a single hmac_sha256 instance.

Parameters:
- ITER_W, 32: width of iteration count and counter.
- SALT_MAX_B, 51: max salt bytes; salt plus 4-byte block index must be at most 55 bytes, the single-block HMAC message limit.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- v_i  in  1  job request valid
- r_o  out  1  ready for job; high only in IDLE
- pwd_i  in  512  password, left aligned, zero filled
- salt_i  in  512  salt, left aligned, zero filled
- salt_len_i  in  6  salt length in bytes
- iter_i  in  ITER_W  iteration count c
- blk_idx_i  in  32  PBKDF2 block index i, normally 1
- dk_o  out  256  derived block T_i
- err_o  out  1  job rejected (salt too long); valid with v_o
- v_o  out  1  result valid
- r_i  in  1  result consumer ready
- hmac_key_o  out  512  HMAC key
- hmac_msg_o  out  512  HMAC message, left aligned
- hmac_len_o  out  6  HMAC message length in bytes
- hmac_v_o  out  1  HMAC request valid
- hmac_r_i  in  1  HMAC accepts request
- hmac_prf_i  in  256  HMAC result
- hmac_v_i  in  1  HMAC result valid
- hmac_r_o  out  1  HMAC result taken

Behaviour:
- Reset (async, rst_ni=0):
  - State goes to IDLE.
  - All registers clear.
  - r_o=1 after reset; v_o, err_o, hmac_v_o, hmac_r_o are 0; dk_o is 0.
  - Reset mid-job drops hmac_v_o immediately and abandons the job. The hmac instance must share the reset.
- A transfer on any channel happens on a cycle with valid&&ready.
- IDLE:
  - r_o=1.
  - On v_i, latch pwd, salt, salt_len, blk_idx and iter; iter=0 is stored as 1.
  - Clear acc and set cnt=1.
  - If salt_len_i>SALT_MAX_B, go to DONE with err=1; otherwise go to SEND.
- SEND:
  - hmac_v_o=1. hmac_key_o, hmac_msg_o and hmac_len_o are driven from registers and stay stable until hmac_r_i.
  - When cnt==1: msg = salt | ({blk_idx, 480'b0} >> 8*salt_len), and len = salt_len+4.
  - When cnt>1: msg = {U_prev, 256'b0}, and len = 32.
  - On hmac_r_i, go to WAIT.
- WAIT:
  - hmac_r_o = hmac_v_i.
  - On the transfer: U_prev <= hmac_prf_i and acc <= acc ^ hmac_prf_i.
  - If cnt==iter, go to DONE; otherwise cnt++ and go to SEND.
- DONE:
  - v_o=1, dk_o=acc, err_o=err. These are held stable until r_i.
  - On r_i, go to IDLE. r_o rises the next cycle.
  - With err=1, dk_o=0.
- Latency: exactly iter HMAC round trips, plus 1 cycle per transition, plus 1 cycle from accept to the first hmac_v_o.
- Boundaries:
  - A request in DONE is ignored because r_o=0.
  - cnt never wraps: iter = 2^ITER_W-1 terminates when cnt==iter.
  - salt_len=0 gives msg = {blk_idx, 480'b0} with len=4.
  - salt_len=51 is legal, with len=55.
  - The key is the password unmodified. Passwords longer than 64 B are out of scope for this block.
- hmac_r_o is never asserted outside WAIT.

Decomposition:
- pbkdf2_pkg holds:
  - state enum {IDLE, SEND, WAIT, DONE};
  - constants HMAC_MAX_B=55, U_BYTES=32, IDX_BYTES=4.
- One sub-module, pbkdf2_msg_build: combinational builder of hmac_msg_o and hmac_len_o from salt, salt_len, blk_idx, U_prev and a first flag.

Test Plan:
1. Real hmac_sha256 attached; P="password", S="salt" (len 4), c=1, i=1 -> dk_o = 120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b; exactly 1 HMAC request with len=8.
2. Same inputs with c=2 -> ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43; second request has len=32 and msg = {U_1, 0}.
3. Same inputs with c=4096 -> c5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a; 4096 requests counted.
4. Stub HMAC returning prf = request count, random hmac_r_i/hmac_v_i stalls, c=3 -> dk_o = 1^2^3 = 0...0; the request stays stable while stalled.
5. salt_len_i=52 -> no hmac_v_o ever, v_o=1, err_o=1, dk_o=0; iter_i=0 -> exactly 1 request issued.
6. r_i held low 10 cycles in DONE -> v_o and dk_o stable, r_o=0, v_i ignored; rst_ni pulsed during WAIT -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/pbkdf2_pkg.sv
// Shared state encoding and byte-size constants for the PBKDF2-HMAC-SHA256 controller.
package pbkdf2_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Single-block HMAC message limit, U_j size and the big-endian block index size.
  localparam int HMAC_MAX_B = 55;
  localparam int U_BYTES    = 32;
  localparam int IDX_BYTES  = 4;

endpackage

// File: rtl/pbkdf2_msg_build.sv
// Builds the HMAC message: salt || INT(i) for U_1, otherwise U_{j-1} zero padded.
module pbkdf2_msg_build
  import pbkdf2_pkg::*;
(
  input  logic [511:0] salt,
  input  logic [5:0]   salt_len,
  input  logic [31:0]  blk_idx,
  input  logic [255:0] u_prev,
  input  logic         first,
  output logic [511:0] msg,
  output logic [5:0]   len
);

  logic [8:0]   shamt;
  logic [511:0] idx_field;

  always_comb begin
    shamt     = {salt_len, 3'b000};
    // Block index lands right after the last salt byte; salt is zero filled beyond salt_len.
    idx_field = {blk_idx, 480'b0} >> shamt;
    if (first) begin
      msg = salt | idx_field;
      len = salt_len + 6'(IDX_BYTES);
    end else begin
      msg = {u_prev, 256'b0};
      len = 6'(U_BYTES);
    end
  end

endmodule

// File: rtl/pbkdf2_sha256_ctrl.sv
// PBKDF2-HMAC-SHA256 iteration controller: issues c HMAC requests and XOR-folds U_1..U_c.
// Handshakes: a channel transfers on any cycle where its valid and ready are both high.
module pbkdf2_sha256_ctrl
  import pbkdf2_pkg::*;
#(
  parameter int ITER_W     = 32,
  parameter int SALT_MAX_B = 51
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              v_i,
  output logic              r_o,
  input  logic [511:0]      pwd_i,
  input  logic [511:0]      salt_i,
  input  logic [5:0]        salt_len_i,
  input  logic [ITER_W-1:0] iter_i,
  input  logic [31:0]       blk_idx_i,
  output logic [255:0]      dk_o,
  output logic              err_o,
  output logic              v_o,
  input  logic              r_i,
  output logic [511:0]      hmac_key_o,
  output logic [511:0]      hmac_msg_o,
  output logic [5:0]        hmac_len_o,
  output logic              hmac_v_o,
  input  logic              hmac_r_i,
  input  logic [255:0]      hmac_prf_i,
  input  logic              hmac_v_i,
  output logic              hmac_r_o,
  output logic [1:0]        state_o
);

  logic [1:0]        state_q;
  logic [511:0]      pwd_q;
  logic [511:0]      salt_q;
  logic [5:0]        salt_len_q;
  logic [31:0]       blk_idx_q;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] cnt_q;
  logic [255:0]      acc_q;
  logic [255:0]      u_q;
  logic              err_q;
  logic              salt_too_long;

  assign salt_too_long = int'(salt_len_i) > SALT_MAX_B;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pwd_q      <= '0;
      salt_q     <= '0;
      salt_len_q <= '0;
      blk_idx_q  <= '0;
      iter_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      u_q        <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (v_i) begin
          pwd_q      <= pwd_i;
          salt_q     <= salt_i;
          salt_len_q <= salt_len_i;
          blk_idx_q  <= blk_idx_i;
          iter_q     <= (iter_i == '0) ? ITER_W'(1) : iter_i;
          cnt_q      <= ITER_W'(1);
          acc_q      <= '0;
          u_q        <= '0;
          err_q      <= salt_too_long;
          state_q    <= salt_too_long ? DONE : SEND;
        end
        SEND: if (hmac_r_i) state_q <= WAIT;
        WAIT: if (hmac_v_i) begin
          u_q   <= hmac_prf_i;
          acc_q <= acc_q ^ hmac_prf_i;
          // Compare before incrementing so iter = all-ones terminates without wrapping.
          if (cnt_q == iter_q) begin
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q + ITER_W'(1);
            state_q <= SEND;
          end
        end
        DONE: if (r_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  pbkdf2_msg_build u_msg_build (
    .salt     (salt_q),
    .salt_len (salt_len_q),
    .blk_idx  (blk_idx_q),
    .u_prev   (u_q),
    .first    (cnt_q == ITER_W'(1)),
    .msg      (hmac_msg_o),
    .len      (hmac_len_o)
  );

  assign hmac_key_o = pwd_q;
  assign hmac_v_o   = (state_q == SEND);
  assign hmac_r_o   = (state_q == WAIT) && hmac_v_i;
  assign r_o        = (state_q == IDLE);
  assign v_o        = (state_q == DONE);
  assign err_o      = v_o && err_q;
  assign dk_o       = (v_o && !err_q) ? acc_q : '0;
  assign state_o    = state_q;

endmodule
